hand_overlay_renderer: RTL

Parametrised, pipelined successor to the two-hand XVGA overlay. Renders NUM_HANDS depth-coloured square markers plus optional gesture grid, centre divider and dead-zone band onto the 1024x768 raster. Hand coordinates are captured once per frame on the falling edge of vsync. Compositing is priority-based, not a bitwise OR. Markers for hands that stop reporting are hidden after a configurable number of frames. Sits between the Kinect hand tracker and the XVGA output mux.

---
 rtl/overlay_pkg.sv | 30 +++
 rtl/depth_colour.sv | 26 ++
 rtl/hand_overlay_renderer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/overlay_pkg.sv
// Shared screen geometry, overlay line positions and colour constants.
// Purpose: common definitions; latency: n/a; backpressure: n/a.
package overlay_pkg;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;

    // Line features are LINE_W pixels wide, starting at the listed position
    localparam logic [11:0] LINE_W     = 12'd3;
    localparam logic [11:0] DIVIDER_X  = 12'd512;
    localparam logic [11:0] GRID_X0    = 12'd341;
    localparam logic [11:0] GRID_X1    = 12'd682;
    localparam logic [11:0] GRID_Y0    = 12'd256;
    localparam logic [11:0] GRID_Y1    = 12'd512;
    localparam logic [11:0] DEADZONE_Y = 12'd512;

    localparam logic [23:0] COL_BG       = 24'h000000;
    localparam logic [23:0] COL_DIVIDER  = 24'hFFFFFF;
    localparam logic [23:0] COL_GRID     = 24'h505050;
    localparam logic [23:0] COL_DEADZONE = 24'h303030;
    localparam logic [23:0] COL_NODEPTH  = 24'h808080;
    localparam logic [23:0] COL_NEAR     = 24'hFF0000;
    localparam logic [23:0] COL_MID      = 24'h00FF00;
    localparam logic [23:0] COL_FAR      = 24'h0000FF;

    function automatic logic in_band(input logic [11:0] p, input logic [11:0] lo);
        return (p >= lo) && (p < lo + LINE_W);
    endfunction

endpackage

// File: rtl/depth_colour.sv
// Maps a latched hand depth to its marker colour.
// Latency: combinational; backpressure: none.
module depth_colour
    import overlay_pkg::*;
#(
    parameter int          W      = 16,
    parameter int unsigned Z_NEAR = 800,
    parameter int unsigned Z_FAR  = 1600
) (
    input  logic [W-1:0] z,
    output logic [23:0]  colour
);
    localparam logic [W-1:0] NEAR = W'(Z_NEAR);
    localparam logic [W-1:0] FAR  = W'(Z_FAR);

    always_comb begin
        colour = COL_FAR;
        if (z == '0)
            colour = COL_NODEPTH;
        else if (z < NEAR)
            colour = COL_NEAR;
        else if (z < FAR)
            colour = COL_MID;
    end

endmodule

// File: rtl/hand_overlay_renderer.sv
// Draws depth-coloured hand markers, grid, divider and dead-zone over the XVGA raster.
// Latency: 2 cycles raster-in to pixel-out; backpressure: none, free-running raster.
module hand_overlay_renderer
    import overlay_pkg::*;
#(
    parameter int          NUM_HANDS   = 2,
    parameter int          COORD_W     = 16,
    parameter int          BLOB_SIZE   = 64,
    parameter int          SCALE_SHIFT = 1,
    parameter int          SCALE_MUL   = 3,
    parameter int          HOLD_FRAMES = 8,
    parameter int unsigned Z_NEAR      = 16'd800,
    parameter int unsigned Z_FAR       = 16'd1600
) (
    input  logic                         vclock,
    input  logic                         reset_n,
    input  logic [10:0]                  hcount,
    input  logic [9:0]                   vcount,
    input  logic                         hsync,
    input  logic                         vsync,
    input  logic                         blank,
    input  logic [NUM_HANDS*COORD_W-1:0] hand_x,
    input  logic [NUM_HANDS*COORD_W-1:0] hand_y,
    input  logic [NUM_HANDS*COORD_W-1:0] hand_z,
    input  logic [NUM_HANDS-1:0]         hand_valid,
    input  logic                         show_grid,
    input  logic                         show_deadzone,
    output logic                         phsync,
    output logic                         pvsync,
    output logic                         pblank,
    output logic [23:0]                  pixel,
    output logic                         frame_strobe
);
    localparam int          SW   = COORD_W + 2;
    localparam logic [7:0]  HOLD = 8'(HOLD_FRAMES);
    localparam logic [11:0] BLOB = 12'(BLOB_SIZE);

    // Camera-to-screen mapping, saturating at the last visible row/column
    function automatic logic [11:0] to_screen(input logic [COORD_W-1:0] c, input int lim);
        logic [SW-1:0] s;
        s = ({2'b00, c} >> SCALE_SHIFT) * SW'(SCALE_MUL);
        return (s > SW'(lim - 1)) ? 12'(lim - 1) : 12'(s);
    endfunction

    logic                 vsync_d;
    logic                 fall;
    logic [11:0]          x_disp [NUM_HANDS];
    logic [11:0]          y_disp [NUM_HANDS];
    logic [COORD_W-1:0]   z_lat  [NUM_HANDS];
    logic [7:0]           age    [NUM_HANDS];
    logic [23:0]          hand_col [NUM_HANDS];
    logic [NUM_HANDS-1:0] visible;

    assign fall = vsync_d & ~vsync;

    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            vsync_d      <= 1'b1;
            frame_strobe <= 1'b0;
            for (int i = 0; i < NUM_HANDS; i++) begin
                x_disp[i] <= '0;
                y_disp[i] <= '0;
                z_lat[i]  <= '0;
                age[i]    <= HOLD;
            end
        end else begin
            vsync_d      <= vsync;
            frame_strobe <= fall;
            if (fall) begin
                for (int i = 0; i < NUM_HANDS; i++) begin
                    x_disp[i] <= to_screen(hand_x[i*COORD_W +: COORD_W], SCREEN_W);
                    y_disp[i] <= to_screen(hand_y[i*COORD_W +: COORD_W], SCREEN_H);
                    z_lat[i]  <= hand_z[i*COORD_W +: COORD_W];
                    if (hand_valid[i])
                        age[i] <= '0;
                    else if (age[i] < HOLD)
                        age[i] <= age[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_HANDS; i++)
            visible[i] = (age[i] < HOLD);
    end

    for (genvar g = 0; g < NUM_HANDS; g++) begin : g_col
        depth_colour #(
            .W      (COORD_W),
            .Z_NEAR (Z_NEAR),
            .Z_FAR  (Z_FAR)
        ) u_depth_colour (
            .z      (z_lat[g]),
            .colour (hand_col[g])
        );
    end

    // Stage 1: hit detection on 12-bit widened coordinates so edge markers never wrap
    logic [11:0]          h_w, v_w;
    logic [NUM_HANDS-1:0] hit_hand;
    logic                 hit_div, hit_grid, hit_dz;

    assign h_w = {1'b0, hcount};
    assign v_w = {2'b00, vcount};

    always_comb begin
        for (int i = 0; i < NUM_HANDS; i++)
            hit_hand[i] = visible[i]
                        && (h_w >= x_disp[i]) && (h_w < x_disp[i] + BLOB)
                        && (v_w >= y_disp[i]) && (v_w < y_disp[i] + BLOB);
        hit_div  = in_band(h_w, DIVIDER_X);
        hit_grid = show_grid && (in_band(h_w, GRID_X0) || in_band(h_w, GRID_X1)
                              || in_band(v_w, GRID_Y0) || in_band(v_w, GRID_Y1));
        hit_dz   = show_deadzone && (v_w >= DEADZONE_Y);
    end

    logic [NUM_HANDS-1:0] s1_hand;
    logic                 s1_div, s1_grid, s1_dz;
    logic                 s1_hsync, s1_vsync, s1_blank;

    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            s1_hand  <= '0;
            s1_div   <= 1'b0;
            s1_grid  <= 1'b0;
            s1_dz    <= 1'b0;
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            s1_blank <= 1'b1;
        end else begin
            s1_hand  <= hit_hand;
            s1_div   <= hit_div;
            s1_grid  <= hit_grid;
            s1_dz    <= hit_dz;
            s1_hsync <= hsync;
            s1_vsync <= vsync;
            s1_blank <= blank;
        end
    end

    // Stage 2: priority compositing, lowest hand index on top
    logic [23:0] colour;

    always_comb begin
        colour = COL_BG;
        if (s1_dz)
            colour = COL_DEADZONE;
        if (s1_grid)
            colour = COL_GRID;
        if (s1_div)
            colour = COL_DIVIDER;
        for (int i = NUM_HANDS - 1; i >= 0; i--)
            if (s1_hand[i])
                colour = hand_col[i];
        if (s1_blank)
            colour = COL_BG;
    end

    always_ff @(posedge vclock) begin
        if (!reset_n) begin
            pixel  <= '0;
            phsync <= 1'b1;
            pvsync <= 1'b1;
            pblank <= 1'b1;
        end else begin
            pixel  <= colour;
            phsync <= s1_hsync;
            pvsync <= s1_vsync;
            pblank <= s1_blank;
        end
    end

endmodule
